// File: rtl/kb_pkg.sv
// Shared keypad scanner types: controller states, code width and the
// row/column to key-code map, so benches can reuse them.
`ifndef KBCODE_WID
`define KBCODE_WID 5
`endif

package kb_pkg;

  typedef enum logic [1:0] {
    SCAN             = 2'd0,
    DEBOUNCE_PRESS   = 2'd1,
    HELD             = 2'd2,
    DEBOUNCE_RELEASE = 2'd3
  } kb_state_e;

  localparam int KB_CODE_W = 4;

  // Indexed by {row, col}; * = 0xE, # = 0xF.
  localparam logic [KB_CODE_W-1:0] KB_CODE_MAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // Lowest-numbered active-low column in a pattern (0 if none low).
  function automatic logic [1:0] kb_low_col(input logic [3:0] col_n);
    logic [1:0] c;
    c = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_n[i]) c = i[1:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/kb_debounce.sv
// Stable-pattern counter. The cycle that asserts restart counts as the first
// stable cycle; done flags the cycle that completes CYC consecutive matches.
module kb_debounce #(
  parameter int unsigned CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic match,
  output logic done
);

  localparam int unsigned CW = (CYC > 2) ? $clog2(CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturating stable-cycle count; any mismatch drops it back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (restart)             cnt_d = CW'(1);
    else if (!match)         cnt_d = '0;
    else if (cnt_q != LAST)  cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign done = match && (cnt_q == LAST);

endmodule

// File: rtl/kb_scanner.sv
// 4x4 keypad scanner: walks active-low rows, debounces a press on the frozen
// row, reports {valid, code} while held and debounces the release.
module kb_scanner
  import kb_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [3:0]             row_out,
  input  logic [3:0]             col_in,
  output logic [`KBCODE_WID-1:0] kb_idx
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  kb_state_e               state_q, state_d;
  logic [1:0]              row_q, row_d;
  logic [SW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [3:0]              col_lat_q, col_lat_d;
  logic [`KBCODE_WID-1:0]  kb_idx_q, kb_idx_d;
  logic [3:0]              row_out_q;
  logic [3:0]              col_s1_q, col_s2_q;
  logic                    db_restart, db_match, db_done;

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
    end
  end

  kb_debounce #(.CYC(DEBOUNCE_CYC)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .restart (db_restart),
    .match   (db_match),
    .done    (db_done)
  );

  // Next-state, row walk and output code selection.
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    scan_cnt_d = scan_cnt_q;
    col_lat_d  = col_lat_q;
    kb_idx_d   = kb_idx_q;
    db_restart = 1'b0;
    db_match   = 1'b0;
    case (state_q)
      SCAN: begin
        db_restart = 1'b1;
        if (col_s2_q != 4'hF) begin
          state_d   = DEBOUNCE_PRESS;
          col_lat_d = col_s2_q;
        end else if (scan_cnt_q == '0) begin
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_LAST;
        end else begin
          scan_cnt_d = scan_cnt_q - 1'b1;
        end
      end
      DEBOUNCE_PRESS: begin
        db_match = (col_s2_q == col_lat_q);
        if (!db_match) begin
          state_d    = SCAN;
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_LAST;
        end else if (db_done) begin
          state_d  = HELD;
          kb_idx_d = {1'b1, KB_CODE_MAP[{row_q, kb_low_col(col_lat_q)}]};
        end
      end
      HELD: begin
        db_restart = 1'b1;
        if (col_s2_q == 4'hF) state_d = DEBOUNCE_RELEASE;
      end
      DEBOUNCE_RELEASE: begin
        db_match = (col_s2_q == 4'hF);
        if (!db_match) begin
          state_d = HELD;
        end else if (db_done) begin
          state_d    = SCAN;
          kb_idx_d   = '0;
          row_d      = row_q + 2'd1;
          scan_cnt_d = SCAN_LAST;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      row_q      <= 2'd0;
      scan_cnt_q <= SCAN_LAST;
      col_lat_q  <= 4'hF;
      kb_idx_q   <= '0;
      row_out_q  <= 4'b1110;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      scan_cnt_q <= scan_cnt_d;
      col_lat_q  <= col_lat_d;
      kb_idx_q   <= kb_idx_d;
      row_out_q  <= ~(4'b0001 << row_d);
    end
  end

  assign row_out = row_out_q;
  assign kb_idx  = kb_idx_q;

endmodule

// File: tb/tb_kb_scanner.sv
// Directed bench for kb_scanner with a keypad model and a cycle model.
module tb_kb_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_out;
  logic [3:0] col_in;
  logic [4:0] kb_idx;
  logic [15:0] keys = '0;   // bit row*4+col = key pressed

  int checks = 0;
  int errors = 0;

  kb_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DC)) dut (
    .clk     (clk),
    .rst     (rst),
    .row_out (row_out),
    .col_in  (col_in),
    .kb_idx  (kb_idx)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  string legend = "123A456B789C*0#D";
  int m_mode;      // 0 scanning, 1 press debounce, 2 held, 3 release debounce
  int m_row, m_tick, m_stable, m_idx;
  logic [3:0] m_s1, m_s2, m_lat, m_seen;

  function automatic int key_code(input byte ch);
    if (ch >= "0" && ch <= "9") return int'(ch) - int'("0");
    if (ch >= "A" && ch <= "D") return int'(ch) - int'("A") + 10;
    if (ch == "*") return 14;
    return 15;
  endfunction

  function automatic int lowest_col(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  // Advance the model one clock using the column value present before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_row = 0; m_tick = 0; m_stable = 0; m_idx = 0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_lat = 4'hF;
    end else begin
      m_seen = m_s2;
      m_s2   = m_s1;
      m_s1   = col_in;
      case (m_mode)
        0: if (m_seen != 4'hF) begin
             m_mode = 1; m_lat = m_seen; m_stable = 1;
           end else begin
             m_tick++;
             if (m_tick == SD) begin m_tick = 0; m_row = (m_row + 1) % 4; end
           end
        1: if (m_seen != m_lat) begin
             m_mode = 0; m_row = (m_row + 1) % 4; m_tick = 0;
           end else begin
             m_stable++;
             if (m_stable == DC) begin
               m_mode = 2;
               m_idx  = 16 + key_code(legend[m_row*4 + lowest_col(m_lat)]);
             end
           end
        2: if (m_seen == 4'hF) begin m_mode = 3; m_stable = 1; end
        default: if (m_seen != 4'hF) m_mode = 2;
           else begin
             m_stable++;
             if (m_stable == DC) begin
               m_idx = 0; m_mode = 0; m_row = (m_row + 1) % 4; m_tick = 0;
             end
           end
      endcase
    end
  end

  // Compare DUT outputs against the model every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (row_out !== ~(4'b0001 << m_row) || kb_idx !== 5'(m_idx)) begin
        errors++;
        $display("FAIL model t=%0t: row_out=%b kb_idx=%h, model row_out=%b kb_idx=%h",
                 $time, row_out, kb_idx, ~(4'b0001 << m_row), 5'(m_idx));
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_row(input logic [3:0] want, input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (row_out !== want && n < budget);
    check("wait_row", {4'h0, row_out}, {4'h0, want});
  endtask

  task automatic wait_idx(input logic [4:0] want, input int budget, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (kb_idx !== want && n < budget);
    check("wait_idx", {3'b0, kb_idx}, {3'b0, want});
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (kb_idx[4] !== 1'b1 && n < budget);
    check("wait_valid", {7'b0, kb_idx[4]}, 8'h01);
  endtask

  logic [3:0] scan_pat [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    int n;
    bit left_row3;
    repeat (3) @(negedge clk);
    check("reset_row", {4'h0, row_out}, 8'h0E);
    check("reset_idx", {3'b0, kb_idx}, 8'h00);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check("scan_row", {4'h0, row_out}, {4'h0, scan_pat[(k/4)%4]});
      check("scan_idx", {3'b0, kb_idx}, 8'h00);
    end

    // key 5: press before row1 is driven, measure latencies
    wait_row(4'hE, 20);
    keys[5] = 1'b1;
    wait_row(4'hD, 20);
    wait_idx(5'h15, 30, n);
    check("press_latency", 8'(n), 8'd10);
    repeat (20) @(negedge clk);
    check("held_idx", {3'b0, kb_idx}, 8'h15);
    check("held_row", {4'h0, row_out}, 8'h0D);
    keys[5] = 1'b0;
    wait_idx(5'h00, 30, n);
    check("release_latency", 8'(n), 8'd10);
    check("resume_row", {4'h0, row_out}, 8'h0B);

    // '#': bounce inside press debounce, then accepted on a later pass
    wait_row(4'hE, 20);
    keys[14] = 1'b1;
    wait_row(4'h7, 20);
    repeat (5) @(negedge clk);
    keys[14] = 1'b0;
    repeat (3) @(negedge clk);
    keys[14] = 1'b1;
    left_row3 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("bounce_no_valid", {3'b0, kb_idx}, 8'h00);
      if (row_out !== 4'h7) left_row3 = 1'b1;
    end
    check("bounce_rescan", {7'b0, left_row3}, 8'h01);
    wait_idx(5'h1F, 60, n);
    repeat (2) @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      keys[14] = 1'b0;
      repeat (3) @(negedge clk);
      keys[14] = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        check("held_bounce", {3'b0, kb_idx}, 8'h1F);
      end
    end
    keys[14] = 1'b0;
    wait_idx(5'h00, 30, n);

    // row0 col0 + col3 together -> lowest column wins (key 1)
    wait_row(4'h7, 20);
    keys[0] = 1'b1; keys[3] = 1'b1;
    wait_valid(30);
    check("multi_col", {3'b0, kb_idx}, 8'h11);
    keys = '0;
    wait_idx(5'h00, 30, n);

    // '*'
    wait_row(4'hE, 20);
    keys[12] = 1'b1;
    wait_valid(40);
    check("star", {3'b0, kb_idx}, 8'h1E);
    keys = '0;
    wait_idx(5'h00, 30, n);

    // 'D' then asynchronous reset while held
    wait_row(4'hE, 20);
    keys[15] = 1'b1;
    wait_valid(40);
    check("key_d", {3'b0, kb_idx}, 8'h1D);
    #2 rst = 1'b1;
    #1;
    check("async_rst_idx", {3'b0, kb_idx}, 8'h00);
    check("async_rst_row", {4'h0, row_out}, 8'h0E);
    keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("post_rst_row", {4'h0, row_out}, {4'h0, scan_pat[(k/4)%4]});
      check("post_rst_idx", {3'b0, kb_idx}, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/kb_scanner.md
KB_SCANNER -- requirements
Module: kb_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clock cycles each row is driven during scanning (minimum 4).
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 500000, meaning consecutive stable cycles needed to accept a press or a release (minimum 2).
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-005 SHALL have port row_out  output  4  meaning keypad row drive, active-low, exactly one bit low at any time after reset.
REQ-006 SHALL have port col_in  input  4  meaning keypad column sense, active-low, asynchronous to clk and externally pulled up.
REQ-007 SHALL have port kb_idx  output  `KBCODE_WID (5)  meaning bit4 is key-held-valid and bits3:0 are the key code, consumed by the memory-mapped I/O at 0xffff_ff34 and 0xffff_ff38.

Function
REQ-008 SHALL pass col_in through a 2-flop synchronizer before any use; all latencies below exclude these 2 cycles.
REQ-009 SHALL implement states SCAN, DEBOUNCE_PRESS, HELD and DEBOUNCE_RELEASE.
REQ-010 In SCAN, SHALL drive row r low for SCAN_DIV cycles, then advance r to (r+1) mod 4, wrapping from row 3 to row 0.
REQ-011 In SCAN, when any synchronized column bit is low, SHALL freeze the row, latch the row index and the column pattern, and enter DEBOUNCE_PRESS.
REQ-012 In DEBOUNCE_PRESS, SHALL count cycles while the column pattern equals the latched pattern, and SHALL return to SCAN at the next row if the pattern changes.
REQ-013 When DEBOUNCE_PRESS reaches DEBOUNCE_CYC stable cycles, SHALL enter HELD and, on the same edge, load kb_idx = {1, code}.
REQ-014 Key code map by (row, col): r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = *,0,#,D. Codes are 0-9 = 0x0-0x9, A-D = 0xA-0xD, * = 0xE, # = 0xF.
REQ-015 If several columns are low in the latched row, SHALL select the lowest column index; keys in other rows are not seen while the row is frozen.
REQ-016 In HELD, SHALL keep row_out and kb_idx constant, and SHALL enter DEBOUNCE_RELEASE when all columns read high.
REQ-017 In DEBOUNCE_RELEASE, SHALL count cycles with all columns high; on reaching DEBOUNCE_CYC, SHALL clear kb_idx to 5'h00 and return to SCAN at row (latched+1) mod 4.
REQ-018 In DEBOUNCE_RELEASE, any low column SHALL return the block to HELD with kb_idx unchanged, so a bounce never glitches the valid bit.
REQ-019 kb_idx[3:0] SHALL hold the last code while kb_idx[4] is high, and SHALL be 0 whenever kb_idx[4] is low.
REQ-020 All outputs SHALL be registered, with no combinational path from col_in to kb_idx.
REQ-021 Counters SHALL be sized $clog2 of their parameter and SHALL saturate, never wrapping.

Reset
REQ-022 On rst high, SHALL asynchronously set the state to SCAN, row index 0, row_out = 4'b1110, kb_idx = 5'h00, all counters and synchronizer flops to idle (columns high).
REQ-023 Reset asserted mid-debounce or while HELD SHALL discard the key with no valid pulse; scanning restarts at row 0 on the first clock after release.

Structure
REQ-024 SHALL take `KBCODE_WID from Const.svh; the state enum and the 16-entry code map SHALL live in a shared package (kb_pkg) so that benches can reuse them.
REQ-025 SHALL instantiate one sub-module, kb_debounce (a stable-pattern counter with match/clear), reused for both press and release.

Verification (SCAN_DIV=4, DEBOUNCE_CYC=8)
REQ-026 After reset -> row_out cycles 1110, 1101, 1011, 0111, 1110, each held for 4 clocks, and kb_idx = 0.
REQ-027 Hold key 5 (row1, col1) for 20 cycles -> kb_idx = 5'h15 exactly 2+8 cycles after row1 is driven with col1 low; release -> kb_idx = 0 after 2+8 cycles.
REQ-028 Press #, then toggle col2 high for 3 cycles inside the press debounce -> no valid output and the scan resumes; while HELD, 3-cycle release bounces -> kb_idx stays 5'h1F.
REQ-029 Hold row0 col0 and col3 together -> kb_idx = 5'h11 (key 1); hold * -> 5'h1E.
REQ-030 Assert rst while HELD on D -> kb_idx = 0 immediately (asynchronously) and row_out = 1110.
